// File: rtl/bf_pair_serializer_pkg.sv
// Shared FFT definitions: word widths, serializer states and the per-stage pair table.
package bf_pair_serializer_pkg;

  localparam int FLOAT_LEN  = 32;
  localparam int CPLX_LEN   = 2 * FLOAT_LEN;
  localparam int FFT_POINTS = 64;
  localparam int NUM_STAGES = 6;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Stage s of a radix-2 SDF pipeline pairs samples FFT_POINTS/2^(s+1) apart.
  function automatic int stage_pair_num(input int stage);
    return FFT_POINTS >> (stage + 1);
  endfunction

  function automatic int stage_addr_len(input int stage);
    int n;
    n = $clog2(stage_pair_num(stage));
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/bf_pair_buffer.sv
// Simple dual-port y2 buffer with registered read, written while filling and read while draining.
module bf_pair_buffer #(
  parameter int word_len = 64,
  parameter int depth    = 32,
  parameter int addr_len = 5
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [addr_len-1:0] wr_addr,
  input  logic [word_len-1:0] wr_data,
  input  logic                rd_en,
  input  logic [addr_len-1:0] rd_addr,
  output logic [word_len-1:0] rd_data
);

  logic [word_len-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bf_pair_serializer.sv
// Serializes butterfly pairs: y1 passes straight through, y2 is buffered and replayed
// as one contiguous block after pair_num pairs have been accepted.
module bf_pair_serializer
  import bf_pair_serializer_pkg::*;
#(
  parameter int float_len = FLOAT_LEN,
  parameter int pair_num  = 32,
  parameter int addr_len  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*float_len-1:0] data_in1,
  input  logic [2*float_len-1:0] data_in2,
  input  logic                   data_in_valid,
  output logic [2*float_len-1:0] data_out,
  output logic                   data_out_valid,
  output logic                   busy,
  output logic                   overflow
);

  localparam int word_len = 2 * float_len;
  localparam logic [addr_len-1:0] last_idx = addr_len'(pair_num - 1);

  state_t              state_reg, state_next;
  logic [addr_len-1:0] wr_cnt_reg, wr_cnt_next;
  logic [addr_len-1:0] rd_cnt_reg, rd_cnt_next;
  logic                overflow_reg, overflow_next;
  logic                valid_reg, valid_next;
  logic [word_len-1:0] y1_reg, y1_next;
  logic                sel_ram_reg, sel_ram_next;
  logic                wr_en, rd_en;
  logic [word_len-1:0] rd_data;

  bf_pair_buffer #(
    .word_len(word_len),
    .depth   (pair_num),
    .addr_len(addr_len)
  ) u_buffer (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_cnt_reg),
    .wr_data(data_in2),
    .rd_en  (rd_en),
    .rd_addr(rd_cnt_reg),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FILL;
      wr_cnt_reg   <= '0;
      rd_cnt_reg   <= '0;
      overflow_reg <= 1'b0;
      valid_reg    <= 1'b0;
      y1_reg       <= '0;
      sel_ram_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_cnt_reg   <= wr_cnt_next;
      rd_cnt_reg   <= rd_cnt_next;
      overflow_reg <= overflow_next;
      valid_reg    <= valid_next;
      y1_reg       <= y1_next;
      sel_ram_reg  <= sel_ram_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wr_cnt_next   = wr_cnt_reg;
    rd_cnt_next   = rd_cnt_reg;
    overflow_next = overflow_reg;
    valid_next    = 1'b0;
    y1_next       = y1_reg;
    sel_ram_next  = sel_ram_reg;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    unique case (state_reg)
      FILL: begin
        if (data_in_valid) begin
          wr_en        = 1'b1;
          y1_next      = data_in1;
          sel_ram_next = 1'b0;
          valid_next   = 1'b1;
          if (wr_cnt_reg == last_idx) begin
            wr_cnt_next = '0;
            state_next  = DRAIN;
          end else begin
            wr_cnt_next = wr_cnt_reg + addr_len'(1);
          end
        end
      end
      DRAIN: begin
        // Pairs arriving now are dropped; the replay continues regardless.
        rd_en        = 1'b1;
        sel_ram_next = 1'b1;
        valid_next   = 1'b1;
        if (data_in_valid) overflow_next = 1'b1;
        if (rd_cnt_reg == last_idx) begin
          rd_cnt_next = '0;
          state_next  = FILL;
        end else begin
          rd_cnt_next = rd_cnt_reg + addr_len'(1);
        end
      end
      default: state_next = FILL;
    endcase
  end

  // The RAM read register and the y1 register both hold their value, so the
  // select alone keeps data_out stable across idle cycles.
  assign data_out       = sel_ram_reg ? rd_data : y1_reg;
  assign data_out_valid = valid_reg;
  assign busy           = (state_reg == DRAIN);
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_bf_pair_serializer.sv
// Randomized and directed checks of bf_pair_serializer at pair_num=4 and pair_num=32.
module tb_bf_pair_serializer;

  localparam int W    = 64;
  localparam int MAXC = 512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in1 = '0;
  logic [W-1:0] data_in2 = '0;
  logic         data_in_valid = 1'b0;
  logic [W-1:0] dout4, dout32;
  logic         v4, v32, b4, b32, o4, o32;

  always #5 clk = ~clk;

  bf_pair_serializer #(.float_len(32), .pair_num(4), .addr_len(2)) u4 (
    .clk(clk), .rst(rst), .data_in1(data_in1), .data_in2(data_in2),
    .data_in_valid(data_in_valid), .data_out(dout4), .data_out_valid(v4),
    .busy(b4), .overflow(o4)
  );

  bf_pair_serializer #(.float_len(32), .pair_num(32), .addr_len(5)) u32 (
    .clk(clk), .rst(rst), .data_in1(data_in1), .data_in2(data_in2),
    .data_in_valid(data_in_valid), .data_out(dout32), .data_out_valid(v32),
    .busy(b32), .overflow(o32)
  );

  int checks = 0;
  int errors = 0;

  logic         st_v [MAXC];
  logic [W-1:0] st_a [MAXC];
  logic [W-1:0] st_b [MAXC];
  logic         exp_v [MAXC];
  logic         exp_b [MAXC];
  logic         exp_o [MAXC];
  logic [W-1:0] exp_d [MAXC];
  logic         ob_v [MAXC];
  logic         ob_b [MAXC];
  logic         ob_o [MAXC];
  logic [W-1:0] ob_d [MAXC];

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_v[i] = 1'b0;
      st_a[i] = '0;
      st_b[i] = '0;
    end
  endtask

  // Reference: each accepted pair shows y1 one cycle later; the pair_num-th pair
  // triggers the whole y2 block right after, during which the block is busy and
  // arriving pairs are lost and flag overflow. Output data holds between valids.
  task automatic build_model(input int pn, input int n);
    logic [W-1:0] y2q[$];
    int ovf_from;
    ovf_from = MAXC;
    y2q.delete();
    for (int c = 0; c < MAXC; c++) begin
      exp_v[c] = 1'b0;
      exp_b[c] = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      if (st_v[c]) begin
        if (exp_b[c]) begin
          if (c + 1 < ovf_from) ovf_from = c + 1;
        end else begin
          exp_v[c+1] = 1'b1;
          exp_d[c+1] = st_a[c];
          y2q.push_back(st_b[c]);
          if (y2q.size() == pn) begin
            for (int i = 0; i < pn; i++) begin
              exp_v[c+2+i] = 1'b1;
              exp_d[c+2+i] = y2q[i];
              exp_b[c+1+i] = 1'b1;
            end
            y2q.delete();
          end
        end
      end
    end
    for (int c = 0; c < MAXC; c++) begin
      if (!exp_v[c]) exp_d[c] = (c == 0) ? '0 : exp_d[c-1];
      exp_o[c] = (c >= ovf_from);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_in1 = '0;
    data_in2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives st_* from cycle 0 after reset and records the selected DUT mid-cycle.
  task automatic run(input int pn, input int n);
    do_reset();
    for (int c = 0; c < n; c++) begin
      data_in_valid = st_v[c];
      data_in1 = st_a[c];
      data_in2 = st_b[c];
      @(negedge clk);
      ob_v[c] = (pn == 4) ? v4 : v32;
      ob_b[c] = (pn == 4) ? b4 : b32;
      ob_o[c] = (pn == 4) ? o4 : o32;
      ob_d[c] = (pn == 4) ? dout4 : dout32;
      @(posedge clk);
      #1;
    end
    data_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_stim();
    run(4, 10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (ob_v[c] !== 1'b0 || ob_b[c] !== 1'b0 || ob_o[c] !== 1'b0 || ob_d[c] !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: valid=%b busy=%b ovf=%b data=%h, required all 0", c, ob_v[c], ob_b[c], ob_o[c], ob_d[c]);
      end
      checks++;
      if (v32 !== 1'b0 || b32 !== 1'b0 || o32 !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle32 cycle %0d: valid=%b busy=%b ovf=%b, required 0", c, v32, b32, o32);
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_contiguous();
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      st_v[i] = 1'b1; st_a[i] = W'(i + 1); st_b[i] = W'(i + 11);
    end
    build_model(4, 12);
    run(4, 12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (ob_v[c] !== exp_v[c] || ob_d[c] !== exp_d[c] || ob_b[c] !== exp_b[c] || ob_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL contiguous cycle %0d: got v=%b d=%0h b=%b o=%b, required v=%b d=%0h b=%b o=%b", c, ob_v[c], ob_d[c], ob_b[c], ob_o[c], exp_v[c], exp_d[c], exp_b[c], exp_o[c]);
      end
    end
    checks++;
    if (ob_d[5] !== 64'd11 || ob_b[4] !== 1'b1 || ob_b[8] !== 1'b0) begin
      errors++;
      $display("FAIL contiguous_points: d[5]=%0h busy[4]=%b busy[8]=%b, required 11,1,0", ob_d[5], ob_b[4], ob_b[8]);
    end
    $display("test_contiguous done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_gapped();
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      st_v[2*i] = 1'b1; st_a[2*i] = W'(i + 1); st_b[2*i] = W'(i + 11);
    end
    build_model(4, 16);
    run(4, 16);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (ob_v[c] !== exp_v[c] || ob_d[c] !== exp_d[c] || ob_b[c] !== exp_b[c] || ob_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL gapped cycle %0d: got v=%b d=%0h b=%b o=%b, required v=%b d=%0h b=%b o=%b", c, ob_v[c], ob_d[c], ob_b[c], ob_o[c], exp_v[c], exp_d[c], exp_b[c], exp_o[c]);
      end
    end
    $display("test_gapped done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_overflow();
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      st_v[i] = 1'b1; st_a[i] = W'(i + 1); st_b[i] = W'(i + 11);
    end
    st_v[5] = 1'b1; st_a[5] = 64'd9; st_b[5] = 64'd99;
    build_model(4, 14);
    run(4, 14);
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (ob_v[c] !== exp_v[c] || ob_d[c] !== exp_d[c] || ob_b[c] !== exp_b[c] || ob_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL overflow cycle %0d: got v=%b d=%0h b=%b o=%b, required v=%b d=%0h b=%b o=%b", c, ob_v[c], ob_d[c], ob_b[c], ob_o[c], exp_v[c], exp_d[c], exp_b[c], exp_o[c]);
      end
    end
    checks++;
    if (ob_o[5] !== 1'b0 || ob_o[6] !== 1'b1 || ob_o[13] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf[5]=%b ovf[6]=%b ovf[13]=%b, required 0,1,1", ob_o[5], ob_o[6], ob_o[13]);
    end
    $display("test_overflow done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    int nvalid;
    clear_stim();
    for (int n = 0; n < 64; n++) begin
      int c;
      c = (n < 32) ? n : n + 32;
      st_v[c] = 1'b1; st_a[c] = W'(n); st_b[c] = W'(100 + n);
    end
    build_model(32, 132);
    run(32, 132);
    nvalid = 0;
    for (int c = 0; c < 132; c++) begin
      if (ob_v[c] === 1'b1) nvalid++;
      checks++;
      if (ob_v[c] !== exp_v[c] || ob_d[c] !== exp_d[c] || ob_b[c] !== exp_b[c] || ob_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got v=%b d=%0h b=%b o=%b, required v=%b d=%0h b=%b o=%b", c, ob_v[c], ob_d[c], ob_b[c], ob_o[c], exp_v[c], exp_d[c], exp_b[c], exp_o[c]);
      end
    end
    checks++;
    if (nvalid != 128 || ob_d[33] !== 64'd100 || ob_d[128] !== 64'd163) begin
      errors++;
      $display("FAIL back_to_back_summary: valids=%0d d[33]=%0d d[128]=%0d, required 128,100,163", nvalid, ob_d[33], ob_d[128]);
    end
    $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid_drain();
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      st_v[i] = 1'b1; st_a[i] = W'(i + 1); st_b[i] = W'(i + 11);
    end
    do_reset();
    for (int c = 0; c < 7; c++) begin
      data_in_valid = st_v[c];
      data_in1 = st_a[c];
      data_in2 = st_b[c];
      @(negedge clk);
      if (c == 6) begin
        checks++;
        if (v4 !== 1'b1 || dout4 !== 64'd12 || b4 !== 1'b1) begin
          errors++;
          $display("FAIL pre_abort: valid=%b data=%0h busy=%b, required 1,12,1", v4, dout4, b4);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (v4 !== 1'b0 || b4 !== 1'b0 || dout4 !== '0) begin
          errors++;
          $display("FAIL async_abort: valid=%b busy=%b data=%0h, required 0,0,0", v4, b4, dout4);
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      st_v[i] = 1'b1; st_a[i] = W'(i + 21); st_b[i] = W'(i + 31);
    end
    build_model(4, 12);
    run(4, 12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (ob_v[c] !== exp_v[c] || ob_d[c] !== exp_d[c] || ob_b[c] !== exp_b[c] || ob_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL after_abort cycle %0d: got v=%b d=%0h b=%b o=%b, required v=%b d=%0h b=%b o=%b", c, ob_v[c], ob_d[c], ob_b[c], ob_o[c], exp_v[c], exp_d[c], exp_b[c], exp_o[c]);
      end
    end
    $display("test_reset_mid_drain done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random(input int pn, input int n);
    clear_stim();
    for (int c = 0; c < n - pn - 4; c++) begin
      st_v[c] = ($urandom_range(0, 3) != 0);
      st_a[c] = {$urandom, $urandom};
      st_b[c] = {$urandom, $urandom};
    end
    build_model(pn, n);
    run(pn, n);
    for (int c = 0; c < n; c++) begin
      checks++;
      if (ob_v[c] !== exp_v[c] || ob_d[c] !== exp_d[c] || ob_b[c] !== exp_b[c] || ob_o[c] !== exp_o[c]) begin
        errors++;
        $display("FAIL random%0d cycle %0d: got v=%b d=%h b=%b o=%b, required v=%b d=%h b=%b o=%b", pn, c, ob_v[c], ob_d[c], ob_b[c], ob_o[c], exp_v[c], exp_d[c], exp_b[c], exp_o[c]);
      end
    end
    $display("test_random pn=%0d done: checks=%0d errors=%0d", pn, checks, errors);
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gapped();
    test_overflow();
    test_back_to_back();
    test_reset_mid_drain();
    test_random(4, 200);
    test_random(32, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
